// File: rtl/id_front_stage.sv
// Decode front half: IF/ID latch, 32x XLEN register file with writeback bypass, load-use hazard detect.
// Optional build macro ID_FRONT_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_front_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            busywait,
  input  logic            branch_jump_signal,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_4_in,
  input  logic            wb_write_en,
  input  logic [4:0]      wb_write_addr,
  input  logic [XLEN-1:0] wb_write_data,
  input  logic            ex_d_mem_r,
  input  logic [4:0]      ex_write_address,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_4_out,
  output logic            valid_out,
  output logic [XLEN-1:0] data_1_out,
  output logic [XLEN-1:0] data_2_out,
  output logic            load_use_stall,
  output logic            ctrl_kill
`ifdef ID_FRONT_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_4_reg;
  logic            valid_reg;
  logic [XLEN-1:0] regs_reg [32];

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      opcode;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [4:0]      rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign opcode = instr_reg[6:0];

  // LUI/AUIPC/JAL carry immediate bits where rs1 would be, so they never create a dependency.
  assign uses_rs1 = !((opcode == 7'b0110111) || (opcode == 7'b0010111) || (opcode == 7'b1101111));
  assign uses_rs2 = (opcode == 7'b0110011) || (opcode == 7'b0100011) || (opcode == 7'b1100011);

  assign load_use_stall = valid_reg & ex_d_mem_r & (ex_write_address != 5'd0) &
                          ((uses_rs1 & (ex_write_address == rs1)) |
                           (uses_rs2 & (ex_write_address == rs2)));

  assign ctrl_kill = load_use_stall | ~valid_reg | branch_jump_signal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      pc_4_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (branch_jump_signal) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      pc_4_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (!busywait && !load_use_stall) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      pc_4_reg  <= pc_4_in;
      valid_reg <= 1'b1;
    end
  end

  // Writeback is never stalled or flushed; x0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_write_en && (wb_write_addr != 5'd0)) begin
      regs_reg[wb_write_addr] <= wb_write_data;
    end
  end

  assign rd_addr[0] = rs1;
  assign rd_addr[1] = rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_data[gi] = (rd_addr[gi] == 5'd0) ? '0 :
                           (wb_write_en && (wb_write_addr == rd_addr[gi])) ? wb_write_data :
                           regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign data_1_out = rd_data[0];
  assign data_2_out = rd_data[1];

  assign instr_out = instr_reg;
  assign pc_out    = pc_reg;
  assign pc_4_out  = pc_4_reg;
  assign valid_out = valid_reg;

`ifdef ID_FRONT_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (load_use_stall && !busywait && (stall_cnt_reg != 32'hFFFFFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (branch_jump_signal && (flush_cnt_reg != 32'hFFFFFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
